// File: rtl/axi_gpio_pkg.sv
// Shared constants for the board GPIO peripheral: register word offsets,
// reset values and input-source geometry.
`timescale 1ns/1ps
package axi_gpio_pkg;

    localparam int NUM_SRC    = 13;
    localparam int NUM_SW     = 8;
    // Holds 16 windows of 10000 cycles (the longest debounce window at 100 MHz).
    localparam int DBNC_CNT_W = 18;

    // Word index, i.e. ADDR[5:2].
    typedef enum logic [3:0] {
        REG_LED        = 4'h0,
        REG_INPUT      = 4'h1,
        REG_INT_STS    = 4'h2,
        REG_INT_EN_SET = 4'h3,
        REG_INT_EN_CLR = 4'h4,
        REG_BTN_EDGE   = 4'h5,
        REG_INT_PEND   = 4'h6,
        REG_DBNC_EN    = 4'h8,
        REG_DBNC_TIME  = 4'h9,
        REG_INT_TEST   = 4'hB
    } reg_idx_e;

    localparam logic [7:0]         RST_LED       = 8'h00;
    localparam logic [NUM_SRC-1:0] RST_INT_STS   = 13'h0000;
    localparam logic [NUM_SRC-1:0] RST_INT_EN    = 13'h0000;
    localparam logic [NUM_SRC-1:0] RST_BTN_EDGE  = 13'h001F;
    localparam logic [NUM_SRC-1:0] RST_DBNC_EN   = 13'h1FFF;
    localparam logic [3:0]         RST_DBNC_TIME = 4'h0;
    localparam logic [NUM_SRC-1:0] BTN_EDGE_MASK = 13'h1F1F;

endpackage

// File: rtl/gpio_debounce.sv
// One input source: 2-flop synchroniser, optional stability filter and
// registered rise/fall pulses of the filtered level.
`timescale 1ns/1ps
module gpio_debounce
    import axi_gpio_pkg::*;
#(
    parameter int CLK_PER_100US = 10000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       dbnc_en,
    input  logic [3:0] dbnc_time,
    input  logic       restart,
    output logic       filt,
    output logic       rise,
    output logic       fall
);

    localparam logic [DBNC_CNT_W-1:0] UNIT = DBNC_CNT_W'(CLK_PER_100US);

    logic                  sync1_reg, sync2_reg;
    logic                  filt_reg, filt_next;
    logic                  rise_reg, fall_reg;
    logic [2:0]            prime_reg;
    logic [DBNC_CNT_W-1:0] cnt_reg, cnt_next;
    logic [DBNC_CNT_W-1:0] limit;

    assign limit = (DBNC_CNT_W'(dbnc_time) + DBNC_CNT_W'(1)) * UNIT - DBNC_CNT_W'(1);

    // Until the synchroniser holds a real sample, the filter just tracks it
    // so that reset release never looks like an edge.
    always_comb begin
        filt_next = filt_reg;
        cnt_next  = '0;
        if (!prime_reg[2] || !dbnc_en) begin
            filt_next = sync2_reg;
        end else if (!restart && (sync2_reg != filt_reg)) begin
            if (cnt_reg == limit)
                filt_next = sync2_reg;
            else
                cnt_next = cnt_reg + DBNC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            filt_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            prime_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prime_reg <= {prime_reg[1:0], 1'b1};
            filt_reg  <= filt_next;
            cnt_reg   <= cnt_next;
            rise_reg  <= prime_reg[2] &  filt_next & ~filt_reg;
            fall_reg  <= prime_reg[2] & ~filt_next &  filt_reg;
        end
    end

    assign filt = filt_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/axi_gpio.sv
// AXI4-Lite GPIO peripheral: LED register, filtered switch/button inputs,
// sticky edge status with enable mask and a registered level interrupt.
`timescale 1ns/1ps
module axi_gpio
    import axi_gpio_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int CLK_PER_100US      = 10000
)(
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            WVALID,
    output logic                            WREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                            BVALID,
    input  logic                            BREADY,
    output logic [1:0]                      BRESP,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic [7:0]                      led,
    input  logic [7:0]                      switch,
    input  logic [4:0]                      button,
    output logic                            interrupt
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic                awready_reg, bvalid_reg, arready_reg, rvalid_reg, irq_reg;
    logic [DW-1:0]       rdata_reg, rdata_next;
    logic [7:0]          led_reg, led_next;
    logic [NUM_SRC-1:0]  sts_reg, sts_next, en_reg, en_next, edge_reg, edge_next;
    logic [NUM_SRC-1:0]  dbnc_en_reg, dbnc_en_next, sts_clr, sts_test;
    logic [3:0]          time_reg, time_next;
    logic [NUM_SRC-1:0]  src, filt, rise, fall, rise_en, fall_en, evt, restart;
    logic [DW-1:0]       wmask, wbits;
    logic [3:0]          wr_idx, rd_idx;
    logic                wr_fire, rd_fire;
    logic                unused_ok;

    assign src     = {button, switch};
    assign wr_idx  = AWADDR[5:2];
    assign rd_idx  = ARADDR[5:2];
    assign wr_fire = awready_reg & AWVALID & WVALID;
    assign rd_fire = arready_reg & ARVALID;
    assign wbits   = WDATA & wmask;

    for (genvar gi = 0; gi < DW/8; gi++) begin : g_strb
        assign wmask[gi*8 +: 8] = {8{WSTRB[gi]}};
    end

    // Switches report both edges; buttons use the BTN_EDGE rise/fall masks.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        if (gi < NUM_SW) begin : g_sw
            assign rise_en[gi] = 1'b1;
            assign fall_en[gi] = 1'b1;
        end else begin : g_btn
            assign rise_en[gi] = edge_reg[gi-NUM_SW];
            assign fall_en[gi] = edge_reg[gi];
        end
        assign evt[gi] = (rise[gi] & rise_en[gi]) | (fall[gi] & fall_en[gi]);

        gpio_debounce #(.CLK_PER_100US(CLK_PER_100US)) u_dbnc (
            .clk       (ACLK),
            .rst_n     (ARESETn),
            .din       (src[gi]),
            .dbnc_en   (dbnc_en_reg[gi]),
            .dbnc_time (time_reg),
            .restart   (restart[gi]),
            .filt      (filt[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

    always_comb begin
        led_next     = led_reg;
        en_next      = en_reg;
        edge_next    = edge_reg;
        dbnc_en_next = dbnc_en_reg;
        time_next    = time_reg;
        sts_clr      = '0;
        sts_test     = '0;
        if (wr_fire) begin
            case (wr_idx)
                REG_LED:        led_next     = (led_reg & ~wmask[7:0]) | wbits[7:0];
                REG_INT_STS:    sts_clr      = wbits[NUM_SRC-1:0];
                REG_INT_EN_SET: en_next      = en_reg | wbits[NUM_SRC-1:0];
                REG_INT_EN_CLR: en_next      = en_reg & ~wbits[NUM_SRC-1:0];
                REG_BTN_EDGE:   edge_next    = ((edge_reg & ~wmask[NUM_SRC-1:0]) | wbits[NUM_SRC-1:0])
                                               & BTN_EDGE_MASK;
                REG_DBNC_EN:    dbnc_en_next = (dbnc_en_reg & ~wmask[NUM_SRC-1:0]) | wbits[NUM_SRC-1:0];
                REG_DBNC_TIME:  time_next    = (time_reg & ~wmask[3:0]) | wbits[3:0];
                REG_INT_TEST:   sts_test     = wbits[NUM_SRC-1:0];
                default:        ;
            endcase
        end
        // Hardware/test sets are applied after the clear so they win a collision.
        sts_next = (sts_reg & ~sts_clr) | evt | sts_test;
    end

    assign restart = (dbnc_en_next ^ dbnc_en_reg) | {NUM_SRC{time_next != time_reg}};

    always_comb begin
        rdata_next = '0;
        case (rd_idx)
            REG_LED:        rdata_next[7:0]         = led_reg;
            REG_INPUT:      rdata_next[NUM_SRC-1:0] = filt;
            REG_INT_STS:    rdata_next[NUM_SRC-1:0] = sts_reg;
            REG_INT_EN_SET: rdata_next[NUM_SRC-1:0] = en_reg;
            REG_INT_EN_CLR: rdata_next[NUM_SRC-1:0] = en_reg;
            REG_BTN_EDGE:   rdata_next[NUM_SRC-1:0] = edge_reg;
            REG_INT_PEND:   rdata_next[NUM_SRC-1:0] = sts_reg & en_reg;
            REG_DBNC_EN:    rdata_next[NUM_SRC-1:0] = dbnc_en_reg;
            REG_DBNC_TIME:  rdata_next[3:0]         = time_reg;
            default:        ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            irq_reg     <= 1'b0;
            led_reg     <= RST_LED;
            sts_reg     <= RST_INT_STS;
            en_reg      <= RST_INT_EN;
            edge_reg    <= RST_BTN_EDGE;
            dbnc_en_reg <= RST_DBNC_EN;
            time_reg    <= RST_DBNC_TIME;
        end else begin
            awready_reg <= !awready_reg && !bvalid_reg && AWVALID && WVALID;
            if (wr_fire)
                bvalid_reg <= 1'b1;
            else if (bvalid_reg && BREADY)
                bvalid_reg <= 1'b0;

            if (rd_fire) begin
                arready_reg <= 1'b0;
                rvalid_reg  <= 1'b1;
                rdata_reg   <= rdata_next;
            end else if (rvalid_reg && RREADY) begin
                arready_reg <= 1'b1;
                rvalid_reg  <= 1'b0;
            end

            irq_reg     <= |(sts_reg & en_reg);
            led_reg     <= led_next;
            sts_reg     <= sts_next;
            en_reg      <= en_next;
            edge_reg    <= edge_next;
            dbnc_en_reg <= dbnc_en_next;
            time_reg    <= time_next;
        end
    end

    assign AWREADY   = awready_reg;
    assign WREADY    = awready_reg;
    assign BVALID    = bvalid_reg;
    assign BRESP     = 2'b00;
    assign ARREADY   = arready_reg;
    assign RVALID    = rvalid_reg;
    assign RDATA     = rdata_reg;
    assign RRESP     = 2'b00;
    assign led       = led_reg;
    assign interrupt = irq_reg;

    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[C_S_AXI_ADDR_WIDTH-1:6], AWADDR[1:0],
                         ARADDR[C_S_AXI_ADDR_WIDTH-1:6], ARADDR[1:0], wbits[DW-1:NUM_SRC]};

endmodule

// File: tb/tb_axi_gpio.sv
// Directed bench for axi_gpio: AXI reads checked through an expected-value
// queue, side-band outputs checked directly at fixed points.
`timescale 1ns/1ps
module tb_axi_gpio;

    localparam int CLK_UNIT = 100;   // cycles per 100 us in this bench

    logic        clk = 1'b0;
    logic        ARESETn = 1'b0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
    logic        ARVALID = 1'b0, RREADY = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = '0;
    logic [2:0]  AWPROT = '0, ARPROT = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, interrupt;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
    logic [7:0]  led;
    logic [7:0]  switch = '0;
    logic [4:0]  button = '0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    axi_gpio #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .CLK_PER_100US(CLK_UNIT)) dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .led(led), .switch(switch), .button(button), .interrupt(interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin @(negedge clk); n++; end
        check("aw_w_ready", {31'b0, AWREADY & WREADY}, 32'h1);
        @(posedge clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 20) begin @(negedge clk); n++; end
        check("bvalid", {31'b0, BVALID}, 32'h1);
        check("bresp", {30'b0, BRESP}, 32'h0);
        @(posedge clk); #1;
        BREADY = 1'b0;
        $display("wr addr=0x%02h data=0x%08h strb=%b", addr, data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int n;
        logic [31:0] e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        ARADDR = addr; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        @(negedge clk);
        n = 0;
        while (!RVALID && n < 20) begin @(negedge clk); n++; end
        check("rvalid", {31'b0, RVALID}, 32'h1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, RDATA, e);
        check("rresp", {30'b0, RRESP}, 32'h0);
        $display("rd addr=0x%02h data=0x%08h", addr, RDATA);
        RREADY = 1'b1;
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_arready", {31'b0, ARREADY}, 32'h1);
        check("rst_awready", {31'b0, AWREADY}, 32'h0);
        check("rst_bvalid",  {31'b0, BVALID}, 32'h0);
        check("rst_rvalid",  {31'b0, RVALID}, 32'h0);
        check("rst_led",     {24'b0, led}, 32'h0);
        check("rst_irq",     {31'b0, interrupt}, 32'h0);
        ARESETn = 1'b1;
        repeat (5) @(negedge clk);
        axi_read(32'h14, 32'h001F, "rst_btn_edge");
        axi_read(32'h20, 32'h1FFF, "rst_dbnc_en");
        axi_read(32'h24, 32'h0,    "rst_dbnc_time");
        axi_read(32'h08, 32'h0,    "rst_int_sts");

        // LED register, byte strobes, unmapped reads
        axi_write(32'h00, 32'h1, 4'hF);
        axi_read(32'h00, 32'h1, "led_rd");
        check("led_out", {24'b0, led}, 32'h01);
        axi_write(32'h00, 32'hAB, 4'h0);
        axi_read(32'h00, 32'h1, "led_strb0");
        axi_read(32'h1C, 32'h0, "unmapped_1c");
        axi_read(32'h2C, 32'h0, "int_test_rd");

        // Enable set/clear
        axi_write(32'h0C, 32'h1FFF, 4'hF);
        axi_write(32'h10, 32'h0102, 4'hF);
        axi_read(32'h0C, 32'h1EFD, "en_set_rd");
        axi_read(32'h10, 32'h1EFD, "en_clr_rd");

        // Switch edge without debounce
        axi_write(32'h20, 32'h0, 4'hF);
        switch[0] = 1'b1;
        repeat (8) @(negedge clk);
        axi_read(32'h08, 32'h1, "sw0_sts");
        check("sw0_irq", {31'b0, interrupt}, 32'h1);
        axi_read(32'h04, 32'h1, "input_rd");
        axi_write(32'h08, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        axi_read(32'h08, 32'h0, "sw0_clr");
        check("sw0_irq_clr", {31'b0, interrupt}, 32'h0);

        // Button edges: bit9 enabled, bit8 disabled in the mask
        axi_write(32'h14, 32'h1F1F, 4'hF);
        axi_read(32'h14, 32'h1F1F, "btn_edge_rd");
        button[1] = 1'b1; repeat (8) @(negedge clk);
        button[1] = 1'b0; repeat (8) @(negedge clk);
        axi_read(32'h08, 32'h200, "btn1_sts");
        check("btn1_irq", {31'b0, interrupt}, 32'h1);
        axi_write(32'h08, 32'h200, 4'hF);
        repeat (2) @(negedge clk);
        button[0] = 1'b1; repeat (8) @(negedge clk);
        button[0] = 1'b0; repeat (8) @(negedge clk);
        axi_read(32'h08, 32'h100, "btn0_sts");
        axi_read(32'h18, 32'h0,   "btn0_pend");
        check("btn0_irq", {31'b0, interrupt}, 32'h0);
        axi_write(32'h08, 32'h1FFF, 4'hF);

        // Debounced button[2], window 100 us
        axi_write(32'h20, 32'h400, 4'hF);
        axi_write(32'h14, 32'h1F, 4'hF);
        button[2] = 1'b1;
        repeat (50) @(negedge clk);
        axi_read(32'h08, 32'h0, "dbnc_early");
        repeat (60) @(negedge clk);
        button[2] = 1'b0;
        repeat (10) @(negedge clk);
        axi_read(32'h08, 32'h400, "dbnc_100us");
        check("dbnc_irq", {31'b0, interrupt}, 32'h1);
        repeat (120) @(negedge clk);
        axi_write(32'h08, 32'h400, 4'hF);

        // Window 200 us: 150 us pulse filtered out, 205 us pulse passes
        axi_write(32'h24, 32'h1, 4'hF);
        button[2] = 1'b1; repeat (150) @(negedge clk);
        button[2] = 1'b0; repeat (220) @(negedge clk);
        axi_read(32'h08, 32'h0, "dbnc_150us");
        button[2] = 1'b1; repeat (205) @(negedge clk);
        button[2] = 1'b0; repeat (10) @(negedge clk);
        axi_read(32'h08, 32'h400, "dbnc_205us");
        repeat (220) @(negedge clk);

        // Software test set and bulk clear
        axi_write(32'h08, 32'h1FFF, 4'hF);
        axi_write(32'h2C, 32'h1, 4'hF);
        axi_read(32'h08, 32'h1, "test_set");
        check("test_irq", {31'b0, interrupt}, 32'h1);
        axi_write(32'h08, 32'h1FFF, 4'hF);
        repeat (2) @(negedge clk);
        axi_read(32'h08, 32'h0, "bulk_clr");
        check("bulk_irq", {31'b0, interrupt}, 32'h0);

        // Reset in the middle of a read, with interrupt asserted
        axi_write(32'h2C, 32'h4, 4'hF);
        repeat (2) @(negedge clk);
        @(negedge clk);
        ARADDR = 32'h14; ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        @(negedge clk);
        check("mid_rvalid", {31'b0, RVALID}, 32'h1);
        check("mid_irq", {31'b0, interrupt}, 32'h1);
        #2 ARESETn = 1'b0;
        #1;
        check("mid_rst_arready", {31'b0, ARREADY}, 32'h1);
        check("mid_rst_rvalid",  {31'b0, RVALID}, 32'h0);
        check("mid_rst_led",     {24'b0, led}, 32'h0);
        check("mid_rst_irq",     {31'b0, interrupt}, 32'h0);
        repeat (2) @(negedge clk);
        ARESETn = 1'b1;
        repeat (8) @(negedge clk);
        axi_read(32'h00, 32'h0,    "post_rst_led");
        axi_read(32'h0C, 32'h0,    "post_rst_en");
        axi_read(32'h14, 32'h001F, "post_rst_edge");
        axi_read(32'h24, 32'h0,    "post_rst_time");
        axi_read(32'h08, 32'h0,    "post_rst_no_edge");
        axi_read(32'h04, 32'h1,    "post_rst_input");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_gpio.md
Name: axi_gpio

Overview:
AXI4-Lite slave peripheral for the board I/O: drives 8 LEDs and samples 8 switches and 5 push-buttons. Each input is synchronised, optionally debounced and edge-detected, and sets a sticky status bit. A level interrupt is raised from status masked by enable. The block sits on the PS general-purpose AXI port.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32).
C_S_AXI_ADDR_WIDTH, 32, AXI address width; only ADDR[5:2] is decoded.
CLK_PER_100US, 10000, ACLK cycles per 100 us debounce unit (100 MHz clock).

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETn  in  1  asynchronous active-low reset.
AWVALID/AWREADY  in/out  1/1  write address handshake.
AWADDR  in  32  write address.
AWPROT  in  3  ignored.
WVALID/WREADY  in/out  1/1  write data handshake.
WDATA  in  32  write data.
WSTRB  in  4  byte strobes.
BVALID/BREADY  out/in  1/1  write response handshake.
BRESP  out  2  always 2'b00 (OKAY).
ARVALID/ARREADY  in/out  1/1  read address handshake.
ARADDR  in  32  read address.
ARPROT  in  3  ignored.
RVALID/RREADY  out/in  1/1  read data handshake.
RDATA  out  32  read data.
RRESP  out  2  always 2'b00.
led  out  8  LED drive.
switch  in  8  asynchronous switch inputs.
button  in  5  asynchronous button inputs.
interrupt  out  1  level interrupt, active high.

Behaviour:
- Reset: all outputs 0 except ARREADY=1; all registers at their reset values below.
- Source index i (0..12): bits 0-7 = switch[7:0], bits 8-12 = button[4:0].
- Write channel: AWREADY and WREADY pulse together for exactly one cycle once AWVALID&WVALID are both high and no response is pending. The register update occurs on that edge, honouring WSTRB per byte. BVALID rises the next cycle and holds until BREADY.
- Read channel: ARREADY is high while idle. On ARVALID&ARREADY, ARREADY drops and RDATA is registered; RVALID rises the next cycle. RDATA and RVALID hold until RREADY, then ARREADY returns high. Unmapped reads return 0 with OKAY.
- Register map (unused bits read 0):
  - 0x00 LED, RW [7:0], reset 0; led = this register.
  - 0x04 INPUT, RO: filtered switch [7:0], filtered button [12:8].
  - 0x08 INT_STS, [12:0] sticky; write-1-to-clear.
  - 0x0C INT_EN_SET: write 1 sets enable bits; reads the enable mask; reset 0.
  - 0x10 INT_EN_CLR: write 1 clears enable bits; reads the enable mask.
  - 0x14 BTN_EDGE: [4:0] rising-edge enable per button, [12:8] falling-edge enable per button; reset 0x001F.
  - 0x18 INT_PEND, RO: INT_STS & enable.
  - 0x20 DBNC_EN, [12:0] per-source debounce enable; reset 0x1FFF.
  - 0x24 DBNC_TIME, [3:0]; debounce window = (DBNC_TIME+1)*100 us; reset 0.
  - 0x2C INT_TEST, write-only: write 1 sets the corresponding INT_STS bit; reads 0.
- Input path, per source:
  - 2-flop synchroniser.
  - Debounce enabled: the filtered value follows the synchronised value only after it has been stable for the full window. Any change restarts the counter.
  - Debounce disabled: filtered = synchronised value.
- Edge events:
  - Switches set their status bit on either edge of the filtered value.
  - Buttons set their status bit on a rising edge if BTN_EDGE[i-8] is set, and on a falling edge if BTN_EDGE[i] is set.
- Status bits set regardless of enable. A hardware set and a software clear in the same cycle: the set wins.
- interrupt = registered |(INT_STS & enable), one cycle after the status or enable change.
- Changing DBNC_EN or DBNC_TIME mid-count restarts that source's counter. No spurious edge is generated at reset release (the filtered value is initialised from the first synchronised sample).

Decomposition:
- Package axi_gpio_pkg: register offsets, register reset values, NUM_SRC=13, debounce counter width.
- One sub-module gpio_debounce (synchroniser, debounce counter, rise/fall pulse outputs), instantiated 13 times.
- AXI slave and register file stay in axi_gpio.

Test Plan:
- Write 0x00=0x1, then read 0x00 -> RDATA=0x1, led=0x01, BRESP=0, RRESP=0.
- Write 0x0C=0x1FFF, write 0x10=0x102, read 0x0C -> 0x1EFD.
- DBNC_EN=0, switch[0] 0->1 -> INT_STS=0x1 and interrupt=1. Write 0x08=0x1 -> INT_STS=0, interrupt=0.
- BTN_EDGE=0x1F1F, press then release button[1] -> INT_STS bit9 set, interrupt=1. Press and release button[0] -> bit8 set, interrupt unaffected while bit8 is disabled.
- DBNC_EN=0x400, BTN_EDGE=0x1F, button[2] high for 101 us -> bit10 set about 100 us after the press. DBNC_TIME=1, pulse of 150 us -> no event; pulse of 205 us -> bit10 set.
- Write 0x2C=0x1 -> INT_STS bit0 set, interrupt=1. Write 0x08=0x1FFF -> all clear. Assert ARESETn low mid-transaction -> all registers reset, ARREADY=1.
